alu_issue_seq: RTL and testbench
================================

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 The block SHALL provide instr_valid  input  1  instruction offered; instr_ready  output  1  block can accept; instr  input  32  MIPS-format instruction word.
REQ-003 The block SHALL provide ld_valid  input  1  register preload strobe; ld_reg  input  5  preload index; ld_data  input  32  preload value.
REQ-004 The block SHALL provide ALU-side ports opcode  output  6, func_field  output  6, A  output  32, B  output  32 (all registered), result  input  32, zero  input  1.
REQ-005 The block SHALL provide wb_valid  output  1  writeback pulse; wb_reg  output  5; wb_data  output  32.
REQ-006 The block SHALL provide mem_valid  output  1  load-address pulse; mem_addr  output  32; branch_taken  output  1  pulse; illegal  output  1  pulse; busy  output  1  high when not IDLE.

Function
REQ-007 The block SHALL contain a 32x32 register file; r0 SHALL always read 0 and writes to r0 SHALL be discarded.
REQ-008 FSM states SHALL be IDLE, EXEC, DONE; instr_ready SHALL equal (state==IDLE && !ld_valid).
REQ-009 IDLE: on ld_valid, regfile[ld_reg] SHALL be written with ld_data; state stays IDLE; ld_valid has priority over instr_valid in the same cycle.
REQ-010 IDLE: on instr_valid && instr_ready, instr SHALL be latched; opcode<=instr[31:26], func_field<=instr[5:0], A<=reg[rs=instr[25:21]]; next state EXEC.
REQ-011 B SHALL be reg[rt=instr[20:16]] for opcode 0x00 and 0x04, and sign-extended instr[15:0] for opcode 0x23.
REQ-012 EXEC: ALU ports SHALL be stable for exactly one cycle; result and zero SHALL be sampled at the end of EXEC; next state DONE.
REQ-013 DONE: exactly one of the following pulses SHALL assert for one cycle, then state returns to IDLE.
REQ-014 Opcode 0x00 with func 0x20/0x22/0x24/0x25/0x2A: wb_valid=1, wb_reg=rd (instr[15:11]), wb_data=sampled result, regfile[rd] written.
REQ-015 Opcode 0x23: mem_valid=1, mem_addr=sampled result; no regfile write.
REQ-016 Opcode 0x04: branch_taken=sampled zero; no other pulse when zero=0 is not an error.
REQ-017 Any other opcode, or opcode 0x00 with any other func: illegal=1, no regfile write, no other pulse.
REQ-018 Latency SHALL be: instruction accepted at edge N, ALU driven N+1..N+2, DONE pulses visible during cycle N+2..N+3; throughput one instruction per 3 cycles.
REQ-019 In IDLE and DONE, opcode/func_field/A/B SHALL hold their last issued values.
REQ-020 wb_reg/wb_data/mem_addr SHALL hold last values when their valid is low.
REQ-021 A write to rd in DONE SHALL be visible to the next instruction accepted in the following IDLE cycle.

Reset
REQ-022 On reset: state=IDLE, all 32 registers=0, opcode/func_field/A/B=0, wb_reg/wb_data/mem_addr=0, all pulses and busy=0.
REQ-023 Reset asserted in EXEC or DONE SHALL abort the instruction with no writeback, mem or branch pulse on the following cycle.
REQ-024 instr_ready SHALL be 0 while reset is high.

Configuration
REQ-025 Macro ALU_ISSUE_SEQ_DBG_EN SHALL, when defined, add ports dbg_raddr  input  5 and dbg_rdata  output  32, a combinational read of the regfile (r0 reads 0).
REQ-026 Without ALU_ISSUE_SEQ_DBG_EN the debug ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Preload r1=0x2222, r2=0x1111; issue 0x00221820 -> ALU sees opcode 0x00 func 0x20 A=0x2222 B=0x1111; wb_valid, wb_reg=3, wb_data=0x3333.
REQ-028 Issue 0x00221824 -> wb_reg=3, wb_data=0x0; issue 0x0041202A -> wb_reg=4, wb_data=0x1.
REQ-029 Issue 0x8C260010 -> B=0x00000010, mem_valid=1, mem_addr=0x2232; issue 0x8C26FFF0 -> B=0xFFFFFFF0, mem_addr=0x2212; no wb_valid.
REQ-030 Preload r5=0x5555; issue 0x10A50000 -> branch_taken=1; issue 0x10A10000 -> branch_taken=0, illegal=0.
REQ-031 Assert ld_valid (r7=0xABCD) and instr_valid in the same IDLE cycle -> load done, instr_ready=0, instruction accepted next cycle; write to r0 -> r0 still reads 0.
REQ-032 Assert reset during EXEC of an add -> no wb_valid, all registers 0, busy=0 next cycle; opcode 0x3F -> illegal pulse only.

Source files
------------

// File: rtl/alu_issue_seq.sv
// Single-issue sequencer: owns a 32x32 register file, feeds an external ALU and routes its
// result to writeback, load address or branch outputs. Define ALU_ISSUE_SEQ_DBG_EN for a debug read port.
module alu_issue_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        ld_valid,
    input  logic [4:0]  ld_reg,
    input  logic [31:0] ld_data,
    output logic [5:0]  opcode,
    output logic [5:0]  func_field,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [31:0] result,
    input  logic        zero,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic        branch_taken,
    output logic        illegal,
    output logic        busy
`ifdef ALU_ISSUE_SEQ_DBG_EN
    ,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        accept;

    logic [31:0] rf_reg [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] b_next;
    logic [4:0]  rd_reg;

    logic        is_alu_op;
    logic        is_lw;
    logic        is_beq;

    // Shift-amount field is not used by any supported instruction.
    logic        unused_shamt;
    assign unused_shamt = ^instr[10:6];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        accept      = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready = !ld_valid && !reset;
                if (instr_valid && instr_ready) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // ---------------- register file ----------------
    // Preloads only happen in IDLE and writebacks only in DONE, so one write port suffices.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (state_reg == IDLE && ld_valid) begin
            rf_we    = 1'b1;
            rf_waddr = ld_reg;
            rf_wdata = ld_data;
        end else if (state_reg == DONE && wb_valid) begin
            rf_we    = 1'b1;
            rf_waddr = wb_reg;
            rf_wdata = wb_data;
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (reset || gi == 0) begin
                    rf_reg[gi] <= 32'd0;
                end else if (rf_we && rf_waddr == 5'(gi)) begin
                    rf_reg[gi] <= rf_wdata;
                end
            end
        end
    endgenerate

    assign rs_data = rf_reg[instr[25:21]];
    assign rt_data = rf_reg[instr[20:16]];
    assign b_next  = (instr[31:26] == OP_LW) ? {{16{instr[15]}}, instr[15:0]} : rt_data;

`ifdef ALU_ISSUE_SEQ_DBG_EN
    assign dbg_rdata = rf_reg[dbg_raddr];
`endif

    // ---------------- decode of the issued instruction ----------------
    always_comb begin
        is_alu_op = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (func_field)
                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: is_alu_op = 1'b1;
                default:                               is_alu_op = 1'b0;
            endcase
        end
    end

    assign is_lw  = (opcode == OP_LW);
    assign is_beq = (opcode == OP_BEQ);

    // ---------------- ALU ports and completion outputs ----------------
    // Completion pulses are registered at the end of EXEC, so they are high exactly while in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode       <= 6'd0;
            func_field   <= 6'd0;
            A            <= 32'd0;
            B            <= 32'd0;
            rd_reg       <= 5'd0;
            wb_valid     <= 1'b0;
            wb_reg       <= 5'd0;
            wb_data      <= 32'd0;
            mem_valid    <= 1'b0;
            mem_addr     <= 32'd0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            mem_valid    <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            if (accept) begin
                opcode     <= instr[31:26];
                func_field <= instr[5:0];
                A          <= rs_data;
                B          <= b_next;
                rd_reg     <= instr[15:11];
            end
            if (state_reg == EXEC) begin
                if (is_alu_op) begin
                    wb_valid <= 1'b1;
                    wb_reg   <= rd_reg;
                    wb_data  <= result;
                end else if (is_lw) begin
                    mem_valid <= 1'b1;
                    mem_addr  <= result;
                end else if (is_beq) begin
                    branch_taken <= zero;
                end else begin
                    illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: a transaction-level model checked every cycle, plus
// directed instructions with hand-computed results.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_reg = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic [5:0]  opcode;
    logic [5:0]  func_field;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        zero;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        branch_taken;
    logic        illegal;
    logic        busy;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    localparam int M_WB  = 0;
    localparam int M_MEM = 1;
    localparam int M_BR  = 2;
    localparam int M_ILL = 3;

    localparam int L_WB  = 0;
    localparam int L_MEM = 1;
    localparam int L_BRT = 2;
    localparam int L_BRN = 3;
    localparam int L_ILL = 4;

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
        .opcode(opcode), .func_field(func_field), .A(A), .B(B),
        .result(result), .zero(zero),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .branch_taken(branch_taken), .illegal(illegal), .busy(busy)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
        if (op == 6'h23) return a + b;
        if (op == 6'h04) return a - b;
        if (op == 6'h00) begin
            case (fn)
                6'h20: return a + b;
                6'h22: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: return 32'hDEADBEEF;
            endcase
        end
        return 32'hDEADBEEF;
    endfunction

    // ---------------- transaction model ----------------
    logic [31:0] m_rf [32];
    bit          m_pending = 1'b0;
    bit          m_stage = 1'b0;
    int          m_kind = 0;
    logic [31:0] m_val = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    logic [5:0]  exp_opcode = 6'd0;
    logic [5:0]  exp_func = 6'd0;
    logic [31:0] exp_a = 32'd0;
    logic [31:0] exp_b = 32'd0;
    bit          exp_wb_v = 1'b0;
    logic [4:0]  exp_wb_reg = 5'd0;
    logic [31:0] exp_wb_data = 32'd0;
    bit          exp_mem_v = 1'b0;
    logic [31:0] exp_mem_addr = 32'd0;
    bit          exp_br = 1'b0;
    bit          exp_ill = 1'b0;

    function automatic logic [31:0] m_a_of(input logic [31:0] iw);
        return m_rf[iw[25:21]];
    endfunction

    function automatic logic [31:0] m_b_of(input logic [31:0] iw);
        if (iw[31:26] == 6'h23) return {{16{iw[15]}}, iw[15:0]};
        return m_rf[iw[20:16]];
    endfunction

    function automatic int m_kind_of(input logic [31:0] iw);
        if (iw[31:26] == 6'h23) return M_MEM;
        if (iw[31:26] == 6'h04) return M_BR;
        if (iw[31:26] == 6'h00 && (iw[5:0] == 6'h20 || iw[5:0] == 6'h22 || iw[5:0] == 6'h24 ||
                                   iw[5:0] == 6'h25 || iw[5:0] == 6'h2A)) return M_WB;
        return M_ILL;
    endfunction

    function automatic logic [31:0] m_val_of(input logic [31:0] iw);
        if (iw[31:26] == 6'h04) return (m_a_of(iw) == m_b_of(iw)) ? 32'd1 : 32'd0;
        return alu_fn(iw[31:26], iw[5:0], m_a_of(iw), m_b_of(iw));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
            m_pending    <= 1'b0;
            m_stage      <= 1'b0;
            exp_opcode   <= 6'd0;
            exp_func     <= 6'd0;
            exp_a        <= 32'd0;
            exp_b        <= 32'd0;
            exp_wb_v     <= 1'b0;
            exp_wb_reg   <= 5'd0;
            exp_wb_data  <= 32'd0;
            exp_mem_v    <= 1'b0;
            exp_mem_addr <= 32'd0;
            exp_br       <= 1'b0;
            exp_ill      <= 1'b0;
        end else begin
            exp_wb_v  <= 1'b0;
            exp_mem_v <= 1'b0;
            exp_br    <= 1'b0;
            exp_ill   <= 1'b0;
            if (m_pending && !m_stage) begin
                m_stage <= 1'b1;
                case (m_kind)
                    M_WB: begin
                        exp_wb_v    <= 1'b1;
                        exp_wb_reg  <= m_rd;
                        exp_wb_data <= m_val;
                    end
                    M_MEM: begin
                        exp_mem_v    <= 1'b1;
                        exp_mem_addr <= m_val;
                    end
                    M_BR:    exp_br  <= m_val[0];
                    default: exp_ill <= 1'b1;
                endcase
            end else if (m_pending) begin
                m_pending <= 1'b0;
                if (m_kind == M_WB && m_rd != 5'd0) m_rf[m_rd] <= m_val;
            end else if (ld_valid) begin
                if (ld_reg != 5'd0) m_rf[ld_reg] <= ld_data;
            end else if (instr_valid) begin
                m_pending  <= 1'b1;
                m_stage    <= 1'b0;
                exp_opcode <= instr[31:26];
                exp_func   <= instr[5:0];
                exp_a      <= m_a_of(instr);
                exp_b      <= m_b_of(instr);
                m_kind     <= m_kind_of(instr);
                m_val      <= m_val_of(instr);
                m_rd       <= instr[15:11];
            end
        end
    end

    // External ALU: answers correctly only during the execute cycle so a mistimed sample shows up.
    always_comb begin
        result = 32'h0BAD0BAD;
        zero   = 1'b1;
        if (m_pending && !m_stage) begin
            result = alu_fn(opcode, func_field, A, B);
            zero   = (result == 32'd0);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("instr_ready", 32'(instr_ready), 32'(!m_pending && !ld_valid && !reset));
            chk("busy", 32'(busy), 32'(m_pending));
            chk("opcode", 32'(opcode), 32'(exp_opcode));
            chk("func_field", 32'(func_field), 32'(exp_func));
            chk("A", A, exp_a);
            chk("B", B, exp_b);
            chk("wb_valid", 32'(wb_valid), 32'(exp_wb_v));
            chk("wb_reg", 32'(wb_reg), 32'(exp_wb_reg));
            chk("wb_data", wb_data, exp_wb_data);
            chk("mem_valid", 32'(mem_valid), 32'(exp_mem_v));
            chk("mem_addr", mem_addr, exp_mem_addr);
            chk("branch_taken", 32'(branch_taken), 32'(exp_br));
            chk("illegal", 32'(illegal), 32'(exp_ill));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic load(input logic [4:0] r, input logic [31:0] d);
        ld_reg   = r;
        ld_data  = d;
        ld_valid = 1'b1;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        $display("load r%0d = 0x%08h", r, d);
    endtask

    task automatic issue(input logic [31:0] iw, input logic [31:0] ea, input logic [31:0] eb,
                         input int kind, input logic [31:0] ev, input logic [4:0] er,
                         output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        instr = iw;
        instr_valid = 1'b1;
        while (!acc && waits < 8) begin
            @(negedge clk);
            acc = instr_ready;
            @(posedge clk);
            #1;
            ld_valid = 1'b0;
            waits++;
        end
        instr_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'(acc), 32'd1);
            return;
        end
        @(negedge clk);
        chk("lit_A", A, ea);
        chk("lit_B", B, eb);
        @(posedge clk);
        @(negedge clk);
        chk("lit_wb_valid", 32'(wb_valid), 32'(kind == L_WB));
        chk("lit_mem_valid", 32'(mem_valid), 32'(kind == L_MEM));
        chk("lit_branch", 32'(branch_taken), 32'(kind == L_BRT));
        chk("lit_illegal", 32'(illegal), 32'(kind == L_ILL));
        if (kind == L_WB) begin
            chk("lit_wb_reg", 32'(wb_reg), 32'(er));
            chk("lit_wb_data", wb_data, ev);
        end
        if (kind == L_MEM) chk("lit_mem_addr", mem_addr, ev);
        $display("instr 0x%08h A=0x%08h B=0x%08h wb=%0b r%0d=0x%08h mem=%0b 0x%08h br=%0b ill=%0b",
                 iw, A, B, wb_valid, wb_reg, wb_data, mem_valid, mem_addr, branch_taken, illegal);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        checking = 1'b1;
        @(negedge clk);
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_A", A, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        load(5'd1, 32'h2222);
        load(5'd2, 32'h1111);
        issue(32'h00221820, 32'h2222, 32'h1111, L_WB, 32'h3333, 5'd3, w);
        issue(32'h00221824, 32'h2222, 32'h1111, L_WB, 32'h0, 5'd3, w);
        issue(32'h0041202A, 32'h1111, 32'h2222, L_WB, 32'h1, 5'd4, w);
        issue(32'h00221822, 32'h2222, 32'h1111, L_WB, 32'h1111, 5'd3, w);
        issue(32'h00221825, 32'h2222, 32'h1111, L_WB, 32'h3333, 5'd3, w);
        issue(32'h00634820, 32'h3333, 32'h3333, L_WB, 32'h6666, 5'd9, w);
        issue(32'h8C260010, 32'h2222, 32'h00000010, L_MEM, 32'h2232, 5'd0, w);
        issue(32'h8C26FFF0, 32'h2222, 32'hFFFFFFF0, L_MEM, 32'h2212, 5'd0, w);
        load(5'd5, 32'h5555);
        issue(32'h10A50000, 32'h5555, 32'h5555, L_BRT, 32'h0, 5'd0, w);
        issue(32'h10A10000, 32'h5555, 32'h2222, L_BRN, 32'h0, 5'd0, w);

        // Preload and instruction offered together: the load wins, the instruction waits a cycle.
        ld_reg   = 5'd7;
        ld_data  = 32'hABCD;
        ld_valid = 1'b1;
        issue(32'h00E03020, 32'hABCD, 32'h0, L_WB, 32'hABCD, 5'd6, w);
        chk("ld_priority_waits", 32'(w), 32'd2);

        issue(32'h00220020, 32'h2222, 32'h1111, L_WB, 32'h3333, 5'd0, w);
        load(5'd0, 32'hFFFF);
        issue(32'h00004020, 32'h0, 32'h0, L_WB, 32'h0, 5'd8, w);
        issue(32'h00221821, 32'h2222, 32'h1111, L_ILL, 32'h0, 5'd0, w);

        // Reset lands during the execute cycle of an add.
        instr = 32'h00221820;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_wb_valid", 32'(wb_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        $display("reset during EXEC: wb=%0b busy=%0b", wb_valid, busy);
        issue(32'h00221820, 32'h0, 32'h0, L_WB, 32'h0, 5'd3, w);
        issue(32'hFC000000, 32'h0, 32'h0, L_ILL, 32'h0, 5'd0, w);

        @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
